// File: rtl/aes_pkg.sv
// Shared constants and compile-time index helpers for the ShiftRows stage.
// Everything here is evaluated at elaboration; no function reaches the netlist as logic.
package aes_pkg;

    // Bit n set means NB=n is a legal Rijndael block width.
    localparam int NB_LEGAL_MASK = (1 << 4) | (1 << 6) | (1 << 8);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    function automatic bit nb_legal(int nb);
        if (nb < 0 || nb > 30) return 1'b0;
        return ((NB_LEGAL_MASK >> nb) & 1) == 1;
    endfunction

    // Row rotation amount; the 256-bit block uses a wider spread on rows 2 and 3.
    function automatic int shift_off(int nb, int r);
        if (nb == 8 && r >= 2) return r + 1;
        return r;
    endfunction

    // LSB of byte (r,c) in a column-major state whose (0,0) byte is the MSB.
    function automatic int byte_lsb(int nb, int r, int c);
        return 32 * nb - 8 - 8 * (4 * c + r);
    endfunction

    function automatic int src_col(int nb, int r, int c, bit inv);
        if (inv) return (c - shift_off(nb, r) + nb) % nb;
        return (c + shift_off(nb, r)) % nb;
    endfunction

endpackage

// File: rtl/shiftrows_stream_if.sv
// Valid/ready bundle for the ShiftRows stage: input side, output side and tag sideband.
// The environment uses the master modport, the stage uses the slave modport.
interface shiftrows_stream_if #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
);
    localparam int W = 32 * NB;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_inv;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_inv, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_inv, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/shiftrows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation, pure wiring plus a 2:1 select.
// Source columns are elaboration constants, so no arithmetic is built on the data.
module shiftrows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] data_i,
    input  logic             inv_i,
    output logic [32*NB-1:0] data_o
);

    generate
        if (!nb_legal(NB)) begin : g_bad_nb
            $error("shiftrows_perm: NB must be 4, 6 or 8");
        end

        for (genvar r = 0; r < 4; r++) begin : g_row
            for (genvar c = 0; c < NB; c++) begin : g_col
                localparam int DST = byte_lsb(NB, r, c);
                localparam int FWD = byte_lsb(NB, r, src_col(NB, r, c, 1'b0));
                localparam int INV = byte_lsb(NB, r, src_col(NB, r, c, 1'b1));

                assign data_o[DST +: 8] = inv_i ? data_i[INV +: 8] : data_i[FWD +: 8];
            end
        end
    endgenerate

endmodule

// File: rtl/shiftrows_stream.sv
// Registered ShiftRows stage: permutation on entry, then a main register M plus one
// skid register S so the stage streams at full rate under back-pressure.
//
// state     | meaning
// ----------+-----------------------------------------------
// OCC_EMPTY | M and S empty, out_valid=0, in_ready=1
// OCC_ONE   | M holds the head entry, S empty, in_ready=1
// OCC_TWO   | M holds the head, S holds the next, in_ready=0
module shiftrows_stream
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    shiftrows_stream_if.slave bus
);

    localparam int W = 32 * NB;

    occ_e             occ_q;
    occ_e             occ_d;

    logic [W-1:0]     perm_data;
    logic [W-1:0]     m_data_q;
    logic [TAG_W-1:0] m_tag_q;
    logic [W-1:0]     s_data_q;
    logic [TAG_W-1:0] s_tag_q;

    logic             out_valid_c;
    logic             in_ready_c;
    logic             accept;
    logic             leave;
    logic             load_m_in;
    logic             load_m_skid;
    logic             load_s;

    shiftrows_perm #(
        .NB (NB)
    ) u_perm (
        .data_i (bus.in_data),
        .inv_i  (bus.in_inv),
        .data_o (perm_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q <= OCC_EMPTY;
        end else begin
            occ_q <= occ_d;
        end
    end

    always_comb begin
        occ_d = occ_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (accept) occ_d = OCC_ONE;
            end
            OCC_ONE: begin
                if (accept && !leave)      occ_d = OCC_TWO;
                else if (!accept && leave) occ_d = OCC_EMPTY;
            end
            OCC_TWO: begin
                if (leave) occ_d = OCC_ONE;
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    // Handshake outputs decode the occupancy register only, so nothing on the
    // input side reaches in_ready or out_valid combinationally.
    always_comb begin
        out_valid_c = 1'b0;
        in_ready_c  = 1'b1;
        case (occ_q)
            OCC_EMPTY: begin
                out_valid_c = 1'b0;
                in_ready_c  = 1'b1;
            end
            OCC_ONE: begin
                out_valid_c = 1'b1;
                in_ready_c  = 1'b1;
            end
            OCC_TWO: begin
                out_valid_c = 1'b1;
                in_ready_c  = 1'b0;
            end
            default: begin
                out_valid_c = 1'b0;
                in_ready_c  = 1'b1;
            end
        endcase
    end

    assign accept = bus.in_valid && in_ready_c;
    assign leave  = out_valid_c && bus.out_ready;

    always_comb begin
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        case (occ_q)
            OCC_EMPTY: load_m_in = accept;
            OCC_ONE: begin
                load_m_in = accept && leave;
                load_s    = accept && !leave;
            end
            OCC_TWO:   load_m_skid = leave;
            default: begin
                load_m_in   = 1'b0;
                load_m_skid = 1'b0;
                load_s      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_data_q <= '0;
            m_tag_q  <= '0;
            s_data_q <= '0;
            s_tag_q  <= '0;
        end else begin
            if (load_m_in) begin
                m_data_q <= perm_data;
                m_tag_q  <= bus.in_tag;
            end else if (load_m_skid) begin
                m_data_q <= s_data_q;
                m_tag_q  <= s_tag_q;
            end
            if (load_s) begin
                s_data_q <= perm_data;
                s_tag_q  <= bus.in_tag;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = m_data_q;
    assign bus.out_tag   = m_tag_q;

endmodule

// File: tb/tb_shiftrows_stream.sv
// Bench for shiftrows_stream: row-rotation reference model with an occupancy queue,
// per-cycle output checks, plus literal vectors for NB=4, 6 and 8.
module tb_shiftrows_stream;

    logic clk;
    logic rst_n;

    shiftrows_stream_if #(.NB(4), .TAG_W(4)) b4 ();
    shiftrows_stream_if #(.NB(6), .TAG_W(4)) b6 ();
    shiftrows_stream_if #(.NB(8), .TAG_W(4)) b8 ();

    shiftrows_stream #(.NB(4), .TAG_W(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    shiftrows_stream #(.NB(6), .TAG_W(4)) u_dut6 (.clk(clk), .rst_n(rst_n), .bus(b6.slave));
    shiftrows_stream #(.NB(8), .TAG_W(4)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    typedef struct {
        logic [127:0] d;
        logic [3:0]   t;
    } ent_t;

    int     n_chk  = 0;
    int     n_fail = 0;
    int     cyc    = 0;
    bit     chk_on = 0;
    bit     bp_on  = 0;
    int     bp_cnt = 0;
    bit     saw_stall = 0;
    bit     stall_flag = 0;
    logic [127:0] hold_d;
    logic [3:0]   hold_t;

    ent_t         mq[$];
    logic [3:0]   obs_t[$];
    logic [127:0] obs_d[$];
    int           obs_c[$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(int nb, logic [255:0] d, int r, int c);
        return d[32*nb - 8 - 8*(4*c + r) +: 8];
    endfunction

    // Reference: load the state into a 4 x nb byte matrix and rotate each row one
    // column at a time, left for ShiftRows and right for InvShiftRows.
    function automatic logic [255:0] model_sr(int nb, logic [255:0] d, bit inv);
        logic [7:0]   st [4][8];
        logic [7:0]   tmp;
        logic [255:0] o;
        int           off;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < nb; c++)
                st[r][c] = get_byte(nb, d, r, c);
        for (int r = 0; r < 4; r++) begin
            off = (nb == 8 && r >= 2) ? r + 1 : r;
            repeat (off) begin
                if (!inv) begin
                    tmp = st[r][0];
                    for (int c = 0; c < nb - 1; c++) st[r][c] = st[r][c+1];
                    st[r][nb-1] = tmp;
                end else begin
                    tmp = st[r][nb-1];
                    for (int c = nb - 1; c > 0; c--) st[r][c] = st[r][c-1];
                    st[r][0] = tmp;
                end
            end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < nb; c++)
                o[32*nb - 8 - 8*(4*c + r) +: 8] = st[r][c];
        return o;
    endfunction

    // Track occupancy and record output transfers on each rising edge.
    always @(posedge clk) begin
        logic [255:0] mt;
        ent_t         e;
        cyc++;
        if (!rst_n) begin
            mq.delete();
            stall_flag = 0;
        end else begin
            stall_flag = b4.out_valid && !b4.out_ready;
            hold_d     = b4.out_data;
            hold_t     = b4.out_tag;
            if (!b4.in_ready) saw_stall = 1;
            if (b4.out_valid && b4.out_ready) begin
                if (mq.size() > 0) void'(mq.pop_front());
                obs_t.push_back(b4.out_tag);
                obs_d.push_back(b4.out_data);
                obs_c.push_back(cyc);
            end
            if (b4.in_valid && b4.in_ready) begin
                mt  = model_sr(4, 256'(b4.in_data), b4.in_inv);
                e.d = mt[127:0];
                e.t = b4.in_tag;
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("occ_out_valid", 256'(b4.out_valid), 256'(mq.size() != 0));
            chk("occ_in_ready", 256'(b4.in_ready), 256'(mq.size() < 2));
            if (b4.out_valid && mq.size() > 0) begin
                chk("stream_data", 256'(b4.out_data), 256'(mq[0].d));
                chk("stream_tag", 256'(b4.out_tag), 256'(mq[0].t));
            end
            if (stall_flag) begin
                chk("hold_data", 256'(b4.out_data), 256'(hold_d));
                chk("hold_tag", 256'(b4.out_tag), 256'(hold_t));
            end
        end
    end

    always @(negedge clk) begin
        if (bp_on) begin
            bp_cnt++;
            b4.out_ready = (bp_cnt <= 4) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send(input logic [127:0] d, input bit inv, input logic [3:0] tag);
        int n;
        n = 0;
        b4.in_valid = 1'b1;
        b4.in_data  = d;
        b4.in_inv   = inv;
        b4.in_tag   = tag;
        while (!b4.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed %0b, expected 1", b4.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic wait_obs(input int want);
        int n;
        n = 0;
        while (obs_t.size() < want && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_count", 256'(obs_t.size()), 256'(want));
    endtask

    initial begin
        logic [127:0] x;
        logic [127:0] y;
        logic [255:0] pat8;
        logic [255:0] pat6;
        logic [255:0] m8;

        rst_n = 1'b0;
        b4.in_valid = 0; b4.in_data = '0; b4.in_inv = 0; b4.in_tag = '0; b4.out_ready = 1;
        b6.in_valid = 0; b6.in_data = '0; b6.in_inv = 0; b6.in_tag = '0; b6.out_ready = 1;
        b8.in_valid = 0; b8.in_data = '0; b8.in_inv = 0; b8.in_tag = '0; b8.out_ready = 1;
        repeat (2) @(negedge clk);

        chk("rst_out_valid", 256'(b4.out_valid), 256'(0));
        chk("rst_in_ready", 256'(b4.in_ready), 256'(1));
        chk("rst_out_data", 256'(b4.out_data), 256'(0));
        chk("rst_out_tag", 256'(b4.out_tag), 256'(0));
        chk("rst_nb8_ready", 256'(b8.in_ready), 256'(1));
        chk("rst_nb6_ready", 256'(b6.in_ready), 256'(1));
        chk_on = 1;
        rst_n  = 1'b1;
        @(negedge clk);

        // Pin the reference model to the FIPS-197 round-1 vector.
        chk("model_fwd", model_sr(4, 256'(FIPS_IN), 1'b0), 256'(FIPS_OUT));
        chk("model_inv", model_sr(4, 256'(FIPS_OUT), 1'b1), 256'(FIPS_IN));

        send(FIPS_IN, 1'b0, 4'd5);
        b4.in_valid = 0;
        chk("fips_fwd_valid", 256'(b4.out_valid), 256'(1));
        chk("fips_fwd_data", 256'(b4.out_data), 256'(FIPS_OUT));
        chk("fips_fwd_tag", 256'(b4.out_tag), 256'(5));

        send(FIPS_OUT, 1'b1, 4'd6);
        b4.in_valid = 0;
        chk("fips_inv_data", 256'(b4.out_data), 256'(FIPS_IN));
        chk("fips_inv_tag", 256'(b4.out_tag), 256'(6));

        // Forward then inverse on consecutive transfers must restore the state.
        x = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(x, 1'b0, 4'd7);
        y = b4.out_data;
        send(y, 1'b1, 4'd8);
        b4.in_valid = 0;
        chk("roundtrip_data", 256'(b4.out_data), 256'(x));
        chk("roundtrip_tag", 256'(b4.out_tag), 256'(8));

        // NB=8 and NB=6 with byte (r,c) = 4c+r.
        pat8 = '0;
        pat6 = '0;
        for (int k = 0; k < 32; k++) pat8[256 - 8 - 8*k +: 8] = 8'(k);
        for (int k = 0; k < 24; k++) pat6[192 - 8 - 8*k +: 8] = 8'(k);
        chk("model_nb8_r3c5", 256'(get_byte(8, model_sr(8, pat8, 1'b0), 3, 5)), 256'(8'h07));
        b8.in_valid = 1; b8.in_data = pat8; b8.in_inv = 0; b8.in_tag = 4'd3;
        b6.in_valid = 1; b6.in_data = pat6[191:0]; b6.in_inv = 0; b6.in_tag = 4'd2;
        @(negedge clk);
        b8.in_valid = 0;
        b6.in_valid = 0;
        chk("nb8_valid", 256'(b8.out_valid), 256'(1));
        chk("nb8_r2c0", 256'(get_byte(8, b8.out_data, 2, 0)), 256'(8'h0E));
        chk("nb8_r3c0", 256'(get_byte(8, b8.out_data, 3, 0)), 256'(8'h13));
        chk("nb8_r3c5", 256'(get_byte(8, b8.out_data, 3, 5)), 256'(8'h07));
        chk("nb8_full", b8.out_data, model_sr(8, pat8, 1'b0));
        chk("nb8_tag", 256'(b8.out_tag), 256'(3));
        chk("nb6_r3c5", 256'(get_byte(6, 256'(b6.out_data), 3, 5)), 256'(8'h0B));
        chk("nb6_full", 256'(b6.out_data), model_sr(6, pat6, 1'b0));
        chk("nb6_tag", 256'(b6.out_tag), 256'(2));

        m8 = model_sr(8, pat8, 1'b1);
        b8.in_valid = 1; b8.in_inv = 1; b8.in_tag = 4'd4;
        @(negedge clk);
        b8.in_valid = 0;
        chk("nb8_inv_full", b8.out_data, m8);
        chk("nb8_inv_r2c0", 256'(get_byte(8, b8.out_data, 2, 0)), 256'(8'h16));

        // Back-pressure: tags 1..8 under a random out_ready.
        @(negedge clk);
        obs_t.delete(); obs_d.delete(); obs_c.delete();
        saw_stall = 0;
        bp_cnt = 0;
        bp_on  = 1;
        for (int t = 1; t <= 8; t++)
            send({$urandom(), $urandom(), $urandom(), $urandom()}, 1'(t % 2), 4'(t));
        b4.in_valid = 0;
        wait_obs(8);
        bp_on = 0;
        b4.out_ready = 1;
        for (int i = 0; i < 8; i++)
            chk($sformatf("bp_order_%0d", i), 256'(obs_t[i]), 256'(i + 1));
        chk("bp_stall_seen", 256'(saw_stall), 256'(1));

        // Full rate: 8 states leave on 8 consecutive edges.
        repeat (2) @(negedge clk);
        obs_t.delete(); obs_d.delete(); obs_c.delete();
        for (int t = 1; t <= 8; t++)
            send({$urandom(), $urandom(), $urandom(), $urandom()}, 1'(t % 2), 4'(t));
        b4.in_valid = 0;
        wait_obs(8);
        if (obs_c.size() == 8)
            chk("full_rate_span", 256'(obs_c[7] - obs_c[0]), 256'(7));

        // Reset with M and S both occupied.
        repeat (2) @(negedge clk);
        b4.out_ready = 0;
        send(128'h11111111222222223333333344444444, 1'b0, 4'd1);
        send(128'h55555555666666667777777788888888, 1'b1, 4'd2);
        chk("pre_rst_full", 256'(b4.in_ready), 256'(0));
        b4.in_data = 128'h99999999aaaaaaaabbbbbbbbcccccccc;
        b4.in_tag  = 4'd3;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 256'(b4.out_valid), 256'(0));
        chk("mid_rst_in_ready", 256'(b4.in_ready), 256'(1));
        chk("mid_rst_out_data", 256'(b4.out_data), 256'(0));
        chk("mid_rst_out_tag", 256'(b4.out_tag), 256'(0));
        rst_n = 1'b1;
        b4.in_valid = 0;
        b4.out_ready = 1;
        obs_t.delete(); obs_d.delete(); obs_c.delete();
        @(negedge clk);
        send(FIPS_IN, 1'b0, 4'd9);
        b4.in_valid = 0;
        repeat (3) @(negedge clk);
        chk("post_rst_count", 256'(obs_t.size()), 256'(1));
        if (obs_t.size() > 0) begin
            chk("post_rst_tag", 256'(obs_t[0]), 256'(9));
            chk("post_rst_data", 256'(obs_d[0]), 256'(FIPS_OUT));
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
